fir_filter: RTL and testbench

//   Direct-form FIR low-order filter for a signed 16-bit sample stream.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_mac_tree.sv | 40 ++++
 rtl/fir_filter.sv | 57 +++++
 tb/tb_fir_filter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, default coefficients and output saturation for the FIR datapath.
package fir_pkg;

    localparam int unsigned NUM_TAPS = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned COEFF_W  = 16;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned PROD_W   = DATA_W + COEFF_W;
    localparam int unsigned ACC_W    = PROD_W + $clog2(NUM_TAPS);

    // Saturation input is widened so any legal accumulator width fits.
    localparam int unsigned SAT_W    = 64;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef coeff_t [NUM_TAPS-1:0]     coeff_arr_t;

    // h[0] sits in the least significant slot and multiplies the newest sample.
    localparam coeff_arr_t DEFAULT_COEFFS = {16'sd4, 16'sd3, 16'sd2, 16'sd1};

    localparam logic signed [SAT_W-1:0] OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [SAT_W-1:0] OUT_MIN = -(64'sd1 <<< (OUT_W - 1));

    function automatic logic signed [OUT_W-1:0] sat_to_out(input logic signed [SAT_W-1:0] acc);
        if (acc > OUT_MAX) begin
            return OUT_W'(OUT_MAX);
        end else if (acc < OUT_MIN) begin
            return OUT_W'(OUT_MIN);
        end
        return OUT_W'(acc);
    endfunction

endpackage

// File: rtl/fir_mac_tree.sv
// Combinational multiply of every tap by its coefficient, summed by a balanced adder tree.
module fir_mac_tree #(
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COEFF_W  = 16,
    parameter int unsigned ACC_W    = 34
) (
    input  logic [NUM_TAPS*DATA_W-1:0]  samples,
    input  logic [NUM_TAPS*COEFF_W-1:0] coeffs,
    output logic signed [ACC_W-1:0]     acc_c
);
    import fir_pkg::*;

    localparam int unsigned PW     = DATA_W + COEFF_W;
    localparam int unsigned LEVELS = $clog2(NUM_TAPS);
    localparam int unsigned LEAVES = 32'(1) << LEVELS;

    // Level 0 holds the sign-extended products (zero-padded to a power of two);
    // each further level halves the node count.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic signed [ACC_W-1:0] sum [LEAVES >> l];
        for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
                if (j < NUM_TAPS) begin : g_tap
                    logic signed [PW-1:0] prod;
                    assign prod = PW'($signed(samples[j*DATA_W +: DATA_W]))
                                * PW'($signed(coeffs[j*COEFF_W +: COEFF_W]));
                    assign sum[j] = ACC_W'(prod);
                end else begin : g_pad
                    assign sum[j] = '0;
                end
            end else begin : g_add
                assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
            end
        end
    end

    assign acc_c = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR: delay line, MAC tree, saturation and registered output.
module fir_filter #(
    parameter int unsigned NUM_TAPS = fir_pkg::NUM_TAPS,
    parameter int unsigned DATA_W   = fir_pkg::DATA_W,
    parameter int unsigned COEFF_W  = fir_pkg::COEFF_W,
    parameter int unsigned OUT_W    = fir_pkg::OUT_W,
    parameter logic [NUM_TAPS*COEFF_W-1:0] COEFFS = fir_pkg::DEFAULT_COEFFS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [OUT_W-1:0]  y_out
);
    import fir_pkg::*;

    localparam int unsigned ACC_L = DATA_W + COEFF_W + $clog2(NUM_TAPS);

    logic signed [DATA_W-1:0]   d [NUM_TAPS-1];
    logic [NUM_TAPS*DATA_W-1:0] taps_c;
    logic signed [ACC_L-1:0]    acc_c;

    // Tap 0 is the live input; tap k is the sample from k edges ago.
    always_comb begin
        taps_c = '0;
        taps_c[DATA_W-1:0] = x_in;
        for (int k = 1; k < NUM_TAPS; k++) begin
            taps_c[k*DATA_W +: DATA_W] = d[k-1];
        end
    end

    fir_mac_tree #(
        .NUM_TAPS (NUM_TAPS),
        .DATA_W   (DATA_W),
        .COEFF_W  (COEFF_W),
        .ACC_W    (ACC_L)
    ) u_mac (
        .samples  (taps_c),
        .coeffs   (COEFFS),
        .acc_c    (acc_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            y_out <= '0;
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
                d[k] <= '0;
            end
        end else begin
            y_out <= OUT_W'(sat_to_out(SAT_W'(acc_c)));
            d[0]  <= x_in;
            for (int k = 1; k < NUM_TAPS - 1; k++) begin
                d[k] <= d[k-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Directed-vector bench for fir_filter: default taps plus an all-32767 instance for saturation.
module tb_fir_filter;

    logic               clk = 1'b0;
    logic               reset;
    logic               reset_sat;
    logic signed [15:0] x_in;
    logic signed [15:0] x_sat;
    logic signed [31:0] y_out;
    logic signed [31:0] y_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_filter u_dut (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .y_out (y_out)
    );

    fir_filter #(
        .COEFFS ({4{16'sd32767}})
    ) u_sat (
        .clk   (clk),
        .reset (reset_sat),
        .x_in  (x_sat),
        .y_out (y_sat)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ramp_exp [10] = '{1, 4, 10, 20, 30, 40, 43, 38, 24, 0};
        int imp_exp  [5]  = '{1, 2, 3, 4, 0};

        reset     = 1'b0;
        reset_sat = 1'b0;
        x_in      = 16'sd0;
        x_sat     = 16'sd0;
        #2;

        // Reset for two edges
        x_in = 16'sd77;
        tick();
        tick();
        check("reset_y", y_out, 32'sd0);
        check("reset_y_sat", y_sat, 32'sd0);

        // Impulse
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x_in = (i == 0) ? 16'sd1 : 16'sd0;
            tick();
            check($sformatf("impulse[%0d]", i), y_out, imp_exp[i]);
        end

        // Ramp 1..6 then zeros
        for (int i = 0; i < 10; i++) begin
            x_in = (i < 6) ? 16'(i + 1) : 16'sd0;
            tick();
            check($sformatf("ramp[%0d]", i), y_out, ramp_exp[i]);
        end

        // Positive saturation
        reset_sat = 1'b1;
        x_sat = 16'sd32767;
        tick();
        check("pos_sat[0]", y_sat, 32'sd1073676289);
        tick();
        check("pos_sat[1]", y_sat, 32'sd2147352578);
        tick();
        check("pos_sat[2]", y_sat, 32'sd2147483647);
        tick();
        check("pos_sat[3]", y_sat, 32'sd2147483647);

        // Negative saturation from a clean history
        reset_sat = 1'b0;
        x_sat = 16'sd0;
        tick();
        check("sat_reset", y_sat, 32'sd0);
        reset_sat = 1'b1;
        x_sat = -16'sd32768;
        tick();
        check("neg_sat[0]", y_sat, -32'sd1073709056);
        tick();
        check("neg_sat[1]", y_sat, -32'sd2147418112);
        tick();
        check("neg_sat[2]", y_sat, -32'sd2147483648);
        tick();
        check("neg_sat[3]", y_sat, -32'sd2147483648);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) begin
            x_in = 16'(i + 1);
            tick();
            check($sformatf("mid_ramp[%0d]", i), y_out, ramp_exp[i]);
        end
        reset = 1'b0;
        x_in  = 16'sd9;
        tick();
        check("mid_reset", y_out, 32'sd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x_in = (i == 0) ? 16'sd1 : 16'sd0;
            tick();
            check($sformatf("post_reset[%0d]", i), y_out, imp_exp[i]);
        end

        // Reset dominance with toggling input, then clean release
        for (int i = 0; i < 4; i++) begin
            x_in = 16'sd1;
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x_in = (i % 2 == 0) ? 16'sd100 : -16'sd100;
            tick();
            check($sformatf("reset_hold[%0d]", i), y_out, 32'sd0);
        end
        reset = 1'b1;
        x_in  = 16'sd0;
        tick();
        check("release_zero", y_out, 32'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
